ksa_pipe: RTL and testbench
===========================

# ksa_pipe

Parametrised, pipelined Kogge-Stone adder/subtractor with a valid/ready stream interface. It generalises the team's fixed 8-bit combinational KSA to any width ≥ 2 and adds a per-transaction subtract mode and status flags. It inserts a register after every prefix row so the block closes timing at wide widths, and it sits between operand-producing logic and downstream consumers in the arithmetic datapath.

## Interface
- WIDTH, 16: operand/sum width in bits; any integer ≥ 2.
- LEVELS, $clog2(WIDTH): number of prefix rows (derived; not overridden).
- LAT, LEVELS+2: pipeline latency in cycles (derived; not overridden).

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when op=0.
- op  in  1  0 = A+B+cin, 1 = A−B (A + ~B + 1).
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result bits.
- cout  out  1  carry out of the MSB (for subtract: 1 = no borrow).
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.

## Operation
- Global pipeline enable: en = ~out_valid | out_ready; in_ready = en. All stages advance together when en=1 and hold when en=0. Bubbles are not collapsed.
- Beat accepted when in_valid & in_ready. Each stage carries a valid bit; an invalid beat still moves but produces no out_valid.
- Stage 0 (PG register): b' = op ? ~b : b; c0 = op ? 1 : cin. Register g_i = a_i & b'_i, p_i = a_i ^ b'_i. Fold carry-in into bit 0: g_0 ← g_0 | (p_0 & c0). Also register c0, a[MSB], and b'[MSB].
- Stages 1..LEVELS (prefix rows): row k combines (G,P)_i with (G,P)_{i−2^(k−1)} for i ≥ 2^(k−1): G = G_hi | (P_hi & G_lo), P = P_hi & P_lo. Positions i < 2^(k−1) pass through. Each row is registered. Original p_i, c0, and the MSB operand bits travel alongside.
- Output stage: carry into bit i is c0 for i=0 and G_{i−1} for i>0. sum_i = p_i ^ carry_i; cout = G_{WIDTH−1}; ovf = (a_msb == b'_msb) & (sum_msb != a_msb); zero = ~|sum. These values are registered into the outputs with out_valid.
- Outputs hold their value while out_valid & ~out_ready.
- Reset (asynchronous, any time, including mid-stream): all stage valid bits, out_valid, sum, cout, ovf and zero go to 0. in_ready = 1 immediately after reset. In-flight beats are discarded.

## Timing
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+LAT−1, i.e. LAT register stages. WIDTH=8 gives LAT=5; WIDTH=16 gives LAT=6; WIDTH=2 gives LAT=3.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure: when out_valid=1 and out_ready=0, in_ready drops combinationally in the same cycle. No beat is lost or duplicated.
- When out_valid=0, the pipeline advances even if out_ready=0, so bubbles drain.
- Simultaneous accept and output handshake in the same cycle is legal and keeps full throughput.
- Non-power-of-two WIDTH: LEVELS = ceil(log2 WIDTH). Rows whose span exceeds WIDTH still register but pass values through.
- Critical path: one Dot cell plus its register per stage. No path crosses stage boundaries.

## Test plan
- Reset/idle (WIDTH=8): hold rst_n=0 → out_valid=0, sum=0, cout=ovf=zero=0, in_ready=1. Assert reset mid-stream with 3 beats in flight → none emerge after release.
- Add latency: one beat a=8'hFF, b=8'h01, cin=0, op=0 → after 5 cycles sum=8'h00, cout=1, zero=1, ovf=0. Then a=8'h7F, b=8'h00, cin=1 → sum=8'h80, ovf=1, cout=0.
- Subtract: a=8'h05, b=8'h07, op=1 → sum=8'hFE, cout=0, ovf=0. Then a=8'h80, b=8'h01 → sum=8'h7F, ovf=1, cout=1.
- Streaming: 256 back-to-back random beats with out_ready=1 → in_ready stays 1, one result per cycle, all results match the reference model in order.
- Backpressure: toggle out_ready randomly at 50% with in_valid random → no loss or duplication, outputs stable while stalled, in_ready == ~out_valid | out_ready every cycle.
- Width sweep: WIDTH ∈ {2, 7, 16, 33, 64}, exhaustive for WIDTH=2 and random otherwise, both ops → sum/cout/ovf/zero match the model and latency equals $clog2(WIDTH)+2.

Source files
------------

// File: rtl/ksa_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready stream interface.
// Latency: $clog2(WIDTH)+2 cycles (PG register, one register per prefix row, output register).
// Backpressure: one global enable; in_ready = ~out_valid | out_ready, all stages hold together.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       operand beat handshake (a, b, cin, op)
//   op                      0: a + b + cin, 1: a - b (cin ignored)
//   out_valid/out_ready     result beat handshake (sum, cout, ovf, zero)
module ksa_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int LEVELS = $clog2(WIDTH);

    logic en;

    // Stage 0 combinational inputs
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p_in;
    logic             c0_in;

    // Group generate is carried through every row; group propagate is not
    // needed after the last row, so it stops one row early.
    logic [WIDTH-1:0] g_n [0:LEVELS];
    logic [WIDTH-1:0] g_q [0:LEVELS];
    logic [WIDTH-1:0] p_n [0:LEVELS-1];
    logic [WIDTH-1:0] p_q [0:LEVELS-1];

    // Side-band values travelling with each beat
    logic [WIDTH-1:0] po_q [0:LEVELS];
    logic [LEVELS:0]  v_q;
    logic [LEVELS:0]  c0_q;
    logic [LEVELS:0]  am_q;
    logic [LEVELS:0]  bm_q;

    // Output stage combinational results
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_n;
    logic             cout_n;
    logic             ovf_n;
    logic             zero_n;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    always_comb begin
        b_eff = op ? ~b : b;
        c0_in = op | cin;
        p_in  = a ^ b_eff;

        // Carry-in is folded into bit 0 so the prefix tree needs no extra column.
        g_n[0]    = a & b_eff;
        g_n[0][0] = (a[0] & b_eff[0]) | (p_in[0] & c0_in);
        p_n[0]    = p_in;

        // Shifting the low operand up by the row span lines up (G,P)_{i-span}
        // with position i; vacated low positions get G=0 / P=1 so they pass through.
        // Spans wider than the word shift everything out and the row is a plain copy.
        for (int k = 1; k <= LEVELS; k++) begin
            g_n[k] = g_q[k-1] | (p_q[k-1] & (g_q[k-1] << (1 << (k-1))));
        end
        for (int k = 1; k < LEVELS; k++) begin
            p_n[k] = p_q[k-1] & ((p_q[k-1] << (1 << (k-1)))
                                 | ~({WIDTH{1'b1}} << (1 << (k-1))));
        end
    end

    always_comb begin
        carry  = {g_q[LEVELS][WIDTH-2:0], c0_q[LEVELS]};
        sum_n  = po_q[LEVELS] ^ carry;
        cout_n = g_q[LEVELS][WIDTH-1];
        ovf_n  = (am_q[LEVELS] == bm_q[LEVELS]) & (sum_n[WIDTH-1] != am_q[LEVELS]);
        zero_n = ~|sum_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q       <= '0;
            c0_q      <= '0;
            am_q      <= '0;
            bm_q      <= '0;
            for (int k = 0; k <= LEVELS; k++) begin
                g_q[k]  <= '0;
                po_q[k] <= '0;
            end
            for (int k = 0; k < LEVELS; k++) begin
                p_q[k] <= '0;
            end
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (en) begin
            // en == in_ready here, so in_valid alone marks an accepted beat.
            v_q[0]  <= in_valid;
            c0_q[0] <= c0_in;
            am_q[0] <= a[WIDTH-1];
            bm_q[0] <= b_eff[WIDTH-1];
            po_q[0] <= p_in;
            for (int k = 0; k <= LEVELS; k++) begin
                g_q[k] <= g_n[k];
            end
            for (int k = 0; k < LEVELS; k++) begin
                p_q[k] <= p_n[k];
            end
            for (int k = 1; k <= LEVELS; k++) begin
                v_q[k]  <= v_q[k-1];
                c0_q[k] <= c0_q[k-1];
                am_q[k] <= am_q[k-1];
                bm_q[k] <= bm_q[k-1];
                po_q[k] <= po_q[k-1];
            end
            out_valid <= v_q[LEVELS];
            sum       <= sum_n;
            cout      <= cout_n;
            ovf       <= ovf_n;
            zero      <= zero_n;
        end
    end

endmodule

// File: tb/tb_ksa_pipe.sv
// Testbench for ksa_pipe: WIDTH=8 main instance plus WIDTH=2 and WIDTH=33 instances.
// Expected results come from an independent integer-add reference model or from constant tables.
module tb_ksa_pipe;

    localparam int W8 = 8,  LAT8 = 5;
    localparam int W2 = 2,  LAT2 = 3;
    localparam int W33 = 33, LAT33 = 8;

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        o;
        logic        z;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       o;
        res_t       e;
    } vec_t;

    typedef struct {
        res_t r;
        int   acc;
    } pend_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- WIDTH=8 instance ----------------
    logic          in_valid, in_ready, cin, op, out_valid, out_ready, cout, ovf, zero;
    logic [W8-1:0] a, b, sum;
    res_t          drv_exp;

    ksa_pipe #(.WIDTH(W8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero));

    // ---------------- WIDTH=2 instance ----------------
    logic          w2_in_valid, w2_in_ready, w2_cin, w2_op, w2_out_valid, w2_cout, w2_ovf, w2_zero;
    logic [W2-1:0] w2_a, w2_b, w2_sum;

    ksa_pipe #(.WIDTH(W2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(w2_in_valid), .in_ready(w2_in_ready),
        .a(w2_a), .b(w2_b), .cin(w2_cin), .op(w2_op), .out_valid(w2_out_valid), .out_ready(1'b1),
        .sum(w2_sum), .cout(w2_cout), .ovf(w2_ovf), .zero(w2_zero));

    // ---------------- WIDTH=33 instance ----------------
    logic           w33_in_valid, w33_in_ready, w33_cin, w33_op, w33_out_valid, w33_cout, w33_ovf, w33_zero;
    logic [W33-1:0] w33_a, w33_b, w33_sum;

    ksa_pipe #(.WIDTH(W33)) u_w33 (
        .clk(clk), .rst_n(rst_n), .in_valid(w33_in_valid), .in_ready(w33_in_ready),
        .a(w33_a), .b(w33_b), .cin(w33_cin), .op(w33_op), .out_valid(w33_out_valid), .out_ready(1'b1),
        .sum(w33_sum), .cout(w33_cout), .ovf(w33_ovf), .zero(w33_zero));

    // ---------------- reference model and check helper ----------------
    function automatic res_t model(int w, logic [63:0] x, logic [63:0] y, logic ci, logic o);
        res_t        r;
        logic [64:0] full;
        logic [63:0] mask, xm, yp, s;
        logic        c0;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        xm   = x & mask;
        yp   = (o ? ~y : y) & mask;
        c0   = o ? 1'b1 : ci;
        full = {1'b0, xm} + {1'b0, yp} + {64'd0, c0};
        s    = full[63:0] & mask;
        r.s  = s;
        r.c  = full[w];
        r.o  = (xm[w-1] == yp[w-1]) && (s[w-1] != xm[w-1]);
        r.z  = (s == 64'd0);
        return r;
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- WIDTH=8 scoreboard / monitor ----------------
    res_t q8[$];
    res_t act8, exp8, held8;
    logic stalled8 = 1'b0;
    logic rdy_rule;
    int   n_out8 = 0;
    int   n_acc8 = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q8.delete();
            stalled8 = 1'b0;
        end else begin
            rdy_rule = ~out_valid | out_ready;
            check("in_ready_rule", in_ready, rdy_rule);
            act8 = '{s: 64'(sum), c: cout, o: ovf, z: zero};
            if (stalled8) begin
                check("stall_valid_hold", out_valid, 1'b1);
                check("stall_data_hold", act8, held8);
            end
            if (out_valid && out_ready) begin
                n_out8++;
                if (q8.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out8: out_valid=1 with sum=%0h, required no pending beat", sum);
                end else begin
                    exp8 = q8.pop_front();
                    check("result8", act8, exp8);
                end
            end
            stalled8 = out_valid && !out_ready;
            held8    = act8;
            if (in_valid && in_ready) begin
                q8.push_back(drv_exp);
                n_acc8++;
            end
        end
    end

    // ---------------- WIDTH=2 / WIDTH=33 monitors (out_ready tied high) ----------------
    pend_t q2[$], q33[$];
    pend_t it2, it33;
    res_t  act2, act33;

    always @(negedge clk) begin
        if (!rst_n) begin
            q2.delete();
        end else begin
            if (w2_out_valid) begin
                if (q2.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out2: out_valid=1, required no pending beat");
                end else begin
                    it2  = q2.pop_front();
                    act2 = '{s: 64'(w2_sum), c: w2_cout, o: w2_ovf, z: w2_zero};
                    check("result_w2", act2, it2.r);
                    check("latency_w2", cyc - it2.acc, LAT2 - 1);
                end
            end
            if (w2_in_valid && w2_in_ready)
                q2.push_back('{r: model(W2, 64'(w2_a), 64'(w2_b), w2_cin, w2_op), acc: cyc + 1});
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q33.delete();
        end else begin
            if (w33_out_valid) begin
                if (q33.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out33: out_valid=1, required no pending beat");
                end else begin
                    it33  = q33.pop_front();
                    act33 = '{s: 64'(w33_sum), c: w33_cout, o: w33_ovf, z: w33_zero};
                    check("result_w33", act33, it33.r);
                    check("latency_w33", cyc - it33.acc, LAT33 - 1);
                end
            end
            if (w33_in_valid && w33_in_ready)
                q33.push_back('{r: model(W33, 64'(w33_a), 64'(w33_b), w33_cin, w33_op), acc: cyc + 1});
        end
    end

    // ---------------- WIDTH=8 driver ----------------
    // Drives one cycle of stimulus just after the rising edge and returns at the
    // following falling edge, reporting whether the beat will be taken.
    task automatic step(input logic v, input logic [7:0] x, input logic [7:0] y,
                        input logic ci, input logic o, input res_t e, input logic rdy,
                        output logic took);
        @(posedge clk);
        #1;
        in_valid  = v;
        a         = x;
        b         = y;
        cin       = ci;
        op        = o;
        drv_exp   = e;
        out_ready = rdy;
        @(negedge clk);
        took = v && in_ready;
    endtask

    task automatic idle(input int n);
        logic t;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, '0, 1'b1, t);
    endtask

    vec_t tbl[9];

    initial begin
        logic       took, v, ci, o, rdy;
        logic [7:0] x, y;
        int         lat, base_out, base_acc;

        tbl[0] = '{a: 8'hFF, b: 8'h01, ci: 1'b0, o: 1'b0, e: '{s: 64'h00, c: 1'b1, o: 1'b0, z: 1'b1}};
        tbl[1] = '{a: 8'h7F, b: 8'h00, ci: 1'b1, o: 1'b0, e: '{s: 64'h80, c: 1'b0, o: 1'b1, z: 1'b0}};
        tbl[2] = '{a: 8'h05, b: 8'h07, ci: 1'b0, o: 1'b1, e: '{s: 64'hFE, c: 1'b0, o: 1'b0, z: 1'b0}};
        tbl[3] = '{a: 8'h80, b: 8'h01, ci: 1'b0, o: 1'b1, e: '{s: 64'h7F, c: 1'b1, o: 1'b1, z: 1'b0}};
        tbl[4] = '{a: 8'h00, b: 8'h00, ci: 1'b0, o: 1'b0, e: '{s: 64'h00, c: 1'b0, o: 1'b0, z: 1'b1}};
        tbl[5] = '{a: 8'h12, b: 8'h12, ci: 1'b0, o: 1'b1, e: '{s: 64'h00, c: 1'b1, o: 1'b0, z: 1'b1}};
        tbl[6] = '{a: 8'h80, b: 8'h80, ci: 1'b0, o: 1'b0, e: '{s: 64'h00, c: 1'b1, o: 1'b1, z: 1'b1}};
        tbl[7] = '{a: 8'h3C, b: 8'hC3, ci: 1'b0, o: 1'b1, e: '{s: 64'h79, c: 1'b0, o: 1'b0, z: 1'b0}};
        tbl[8] = '{a: 8'h7F, b: 8'h7F, ci: 1'b1, o: 1'b0, e: '{s: 64'hFF, c: 1'b0, o: 1'b1, z: 1'b0}};

        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 1'b0; out_ready = 1'b0; drv_exp = '0;
        w2_in_valid = 1'b0; w2_a = '0; w2_b = '0; w2_cin = 1'b0; w2_op = 1'b0;
        w33_in_valid = 1'b0; w33_a = '0; w33_b = '0; w33_cin = 1'b0; w33_op = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, 8'h00);
        check("rst_flags", {cout, ovf, zero}, 3'b000);
        check("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        idle(2);

        // Single-beat latency
        step(1'b1, tbl[0].a, tbl[0].b, tbl[0].ci, tbl[0].o, tbl[0].e, 1'b1, took);
        lat = 0;
        do begin
            idle(1);
            lat++;
        end while (!out_valid && lat < 20);
        check("latency8", lat, LAT8);
        idle(4);

        // Directed table, back to back
        for (int i = 0; i < 9; i++)
            step(1'b1, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].o, tbl[i].e, 1'b1, took);
        idle(10);

        // Streaming: 256 random beats, full throughput
        base_out = n_out8;
        for (int i = 0; i < 256; i++) begin
            x  = 8'($urandom);
            y  = 8'($urandom);
            ci = 1'($urandom);
            o  = 1'($urandom);
            step(1'b1, x, y, ci, o, model(W8, 64'(x), 64'(y), ci, o), 1'b1, took);
            check("stream_in_ready", took, 1'b1);
            if (i >= LAT8) check("stream_out_valid", out_valid, 1'b1);
        end
        idle(10);
        check("stream_count", n_out8 - base_out, 256);

        // Reset with three beats in flight
        base_out = n_out8;
        for (int i = 0; i < 3; i++)
            step(1'b1, 8'(i + 1), 8'h10, 1'b0, 1'b0, model(W8, 64'(i + 1), 64'h10, 1'b0, 1'b0), 1'b1, took);
        idle(1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        idle(2);
        rst_n = 1'b1;
        idle(12);
        check("midrst_no_output", n_out8 - base_out, 0);

        // Backpressure: random in_valid and out_ready
        base_out = n_out8;
        base_acc = n_acc8;
        x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom); o = 1'($urandom);
        for (int i = 0; i < 400; i++) begin
            v   = 1'($urandom);
            rdy = 1'($urandom);
            step(v, x, y, ci, o, model(W8, 64'(x), 64'(y), ci, o), rdy, took);
            if (took) begin
                x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom); o = 1'($urandom);
            end
        end
        idle(15);
        check("bp_count", n_out8 - base_out, n_acc8 - base_acc);
        check("bp_queue_empty", q8.size(), 0);

        // Width sweep: WIDTH=2 exhaustive, WIDTH=33 random, both ops
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            w2_in_valid  = 1'b1;
            {w2_op, w2_cin, w2_a, w2_b} = 6'(i);
            w33_in_valid = 1'b1;
            w33_a   = {1'($urandom), 32'($urandom)};
            w33_b   = (i % 8 == 0) ? w33_a : {1'($urandom), 32'($urandom)};
            w33_cin = 1'($urandom);
            w33_op  = 1'($urandom);
        end
        @(posedge clk);
        #1;
        w2_in_valid  = 1'b0;
        w33_in_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("w2_queue_empty", q2.size(), 0);
        check("w33_queue_empty", q33.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion before 200000");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule
